// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: command and FSM state
// encodings, stack-pointer width and derived depth constants.
package stack_ctrl_pkg;

   localparam int unsigned SP_W      = 8;
   localparam int unsigned DEPTH_W   = SP_W + 1;
   localparam int unsigned MAX_DEPTH = 1 << SP_W;

   typedef enum logic [1:0] {
      LOAD = 2'b00,
      PUSH = 2'b01,
      POP  = 2'b10,
      NOP  = 2'b11
   } stack_op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PUSH_WR = 2'b01,
      POP_RD  = 2'b10,
      POP_CAP = 2'b11
   } stack_state_t;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command/pop handshake and scratch-RAM bus of the stack controller.
//   cmd_valid/cmd_ready/cmd_op/load_val/push_data : command transfer
//   pop_data/pop_valid                            : popped word + pulse
//   scr_addr/scr_we/scr_din/scr_dout              : external scratch RAM
// slave  : the stack controller
// master : the requester plus scratch RAM
interface stack_ctrl_if
   import stack_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 10
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   stack_op_t         cmd_op;
   logic [SP_W-1:0]   load_val;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] pop_data;
   logic              pop_valid;
   logic [SP_W-1:0]   scr_addr;
   logic              scr_we;
   logic [DATA_W-1:0] scr_din;
   logic [DATA_W-1:0] scr_dout;

   modport slave (
      input  cmd_valid, cmd_op, load_val, push_data, scr_dout,
      output cmd_ready, pop_data, pop_valid, scr_addr, scr_we, scr_din
   );

   modport master (
      output cmd_valid, cmd_op, load_val, push_data, scr_dout,
      input  cmd_ready, pop_data, pop_valid, scr_addr, scr_we, scr_din
   );

endinterface

// File: rtl/stack_ctrl.sv
// Descending stack controller over an external synchronous-read scratch RAM.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : command handshake, pop result, scratch-RAM bus (slave side)
//   err_clr    : clears sticky error flags (a same-cycle set wins)
//   sp, sp_m1  : stack pointer and sp-1 mod 256
//   depth      : stored word count 0..256; full/empty decode it
//   ovf_err    : sticky push-when-full flag
//   unf_err    : sticky pop-when-empty flag
// Push writes at sp-1 then decrements sp; pop reads at sp then increments sp.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter logic [SP_W-1:0] SP_RESET = 8'h00,
   parameter int unsigned     DATA_W   = 10
) (
   input  logic               clk,
   input  logic               rst,
   stack_ctrl_if.slave        bus,
   input  logic               err_clr,
   output logic [SP_W-1:0]    sp,
   output logic [SP_W-1:0]    sp_m1,
   output logic [DEPTH_W-1:0] depth,
   output logic               full,
   output logic               empty,
   output logic               ovf_err,
   output logic               unf_err
);

   stack_state_t       state_q, state_n;
   logic [SP_W-1:0]    sp_q, sp_n;
   logic [DEPTH_W-1:0] depth_q, depth_n;
   logic [DATA_W-1:0]  data_q, data_n;
   logic [DATA_W-1:0]  pop_data_q, pop_data_n;
   logic               pop_valid_q, pop_valid_n;
   logic               ovf_q, ovf_n;
   logic               unf_q, unf_n;
   logic               ovf_set, unf_set;
   logic               xfer;
   logic [SP_W-1:0]    sp_dec;

   assign sp_dec = sp_q - SP_W'(1);
   assign full   = (depth_q == DEPTH_W'(MAX_DEPTH));
   assign empty  = (depth_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_n;
   end

   always_comb begin
      state_n       = state_q;
      sp_n          = sp_q;
      depth_n       = depth_q;
      data_n        = data_q;
      pop_data_n    = pop_data_q;
      pop_valid_n   = 1'b0;
      ovf_set       = 1'b0;
      unf_set       = 1'b0;
      bus.cmd_ready = (state_q == IDLE);
      bus.scr_we    = 1'b0;
      bus.scr_addr  = sp_q;
      bus.scr_din   = data_q;
      xfer          = bus.cmd_valid && (state_q == IDLE);

      case (state_q)
         IDLE: begin
            if (xfer) begin
               case (bus.cmd_op)
                  LOAD: begin
                     sp_n    = bus.load_val;
                     depth_n = '0;
                  end
                  PUSH: begin
                     // Full push is consumed here with only the error flag.
                     if (full) begin
                        ovf_set = 1'b1;
                     end else begin
                        data_n  = bus.push_data;
                        state_n = PUSH_WR;
                     end
                  end
                  POP: begin
                     if (empty) unf_set = 1'b1;
                     else       state_n = POP_RD;
                  end
                  default: ;
               endcase
            end
         end
         PUSH_WR: begin
            bus.scr_addr = sp_dec;
            bus.scr_we   = 1'b1;
            sp_n         = sp_dec;
            depth_n      = depth_q + DEPTH_W'(1);
            state_n      = IDLE;
         end
         POP_RD: begin
            bus.scr_addr = sp_q;
            state_n      = POP_CAP;
         end
         POP_CAP: begin
            // RAM data addressed in POP_RD is valid in this cycle.
            pop_data_n  = bus.scr_dout;
            pop_valid_n = 1'b1;
            sp_n        = sp_q + SP_W'(1);
            depth_n     = depth_q - DEPTH_W'(1);
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase

      ovf_n = (ovf_q && !err_clr) || ovf_set;
      unf_n = (unf_q && !err_clr) || unf_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q        <= SP_RESET;
         depth_q     <= '0;
         data_q      <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         sp_q        <= sp_n;
         depth_q     <= depth_n;
         data_q      <= data_n;
         pop_data_q  <= pop_data_n;
         pop_valid_q <= pop_valid_n;
         ovf_q       <= ovf_n;
         unf_q       <= unf_n;
      end
   end

   assign sp            = sp_q;
   assign sp_m1         = sp_dec;
   assign depth         = depth_q;
   assign ovf_err       = ovf_q;
   assign unf_err       = unf_q;
   assign bus.pop_data  = pop_data_q;
   assign bus.pop_valid = pop_valid_q;

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The module SHALL have parameter SP_RESET, default 8'h00, giving the stack-pointer value after reset.
REQ-002 The module SHALL have parameter DATA_W, default 10, giving the width of a stack word.
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, asynchronous and active-high.
REQ-005 CMD_VALID  in  1  requester has a command on CMD_OP.
REQ-006 CMD_READY  out  1  block accepts a command this cycle; a command transfers when CMD_VALID and CMD_READY are both high.
REQ-007 CMD_OP  in  2  command: 00 LOAD, 01 PUSH, 10 POP, 11 NOP.
REQ-008 LOAD_VAL  in  8  new SP value for LOAD.
REQ-009 PUSH_DATA  in  DATA_W  word to push.
REQ-010 POP_DATA  out  DATA_W  last popped word, held until the next pop completes.
REQ-011 POP_VALID  out  1  one-cycle pulse when POP_DATA updates.
REQ-012 SP  out  8  current stack pointer, feeding the scratch-address select stage.
REQ-013 SP_M1  out  8  SP-1 modulo 256, feeding the scratch-address select stage.
REQ-014 SCR_ADDR  out  8  scratch-RAM address.
REQ-015 SCR_WE  out  1  scratch-RAM write strobe.
REQ-016 SCR_DIN  out  DATA_W  scratch-RAM write data.
REQ-017 SCR_DOUT  in  DATA_W  scratch-RAM read data, valid one cycle after the address is presented (synchronous read).
REQ-018 DEPTH  out  9  stored-word count, range 0..256.
REQ-019 FULL and EMPTY  out  1 each  FULL is DEPTH==256; EMPTY is DEPTH==0.
REQ-020 OVF_ERR and UNF_ERR  out  1 each  sticky overflow and underflow flags.
REQ-021 ERR_CLR  in  1  clears both sticky flags.

Function
REQ-022 The FSM SHALL have the states IDLE, PUSH_WR, POP_RD and POP_CAP; CMD_READY SHALL be high only in IDLE.
REQ-023 A NOP transfer, or CMD_VALID low, SHALL leave all state unchanged.
REQ-024 A LOAD transfer SHALL set SP to LOAD_VAL and DEPTH to 0 at the same edge, and the FSM SHALL stay in IDLE.
REQ-025 A PUSH transfer with FULL low SHALL latch PUSH_DATA and go to PUSH_WR.
REQ-026 In PUSH_WR the block SHALL drive SCR_ADDR=SP_M1, SCR_WE=1 and SCR_DIN=latched data; at the end of that cycle SP SHALL become SP-1 modulo 256, DEPTH SHALL increment, and the FSM SHALL return to IDLE.
REQ-027 A POP transfer with EMPTY low SHALL go to POP_RD.
REQ-028 In POP_RD the block SHALL drive SCR_ADDR=SP with SCR_WE=0, then go to POP_CAP.
REQ-029 In POP_CAP the block SHALL register SCR_DOUT into POP_DATA and pulse POP_VALID in the following cycle; at the end of POP_CAP, SP SHALL become SP+1 modulo 256, DEPTH SHALL decrement, and the FSM SHALL return to IDLE.
REQ-030 A PUSH transfer with FULL high SHALL be consumed with no write and no SP or DEPTH change, SHALL set OVF_ERR, and the FSM SHALL stay in IDLE.
REQ-031 A POP transfer with EMPTY high SHALL be consumed with no read, no POP_VALID pulse and no SP or DEPTH change, SHALL set UNF_ERR, and the FSM SHALL stay in IDLE.
REQ-032 When ERR_CLR and an error set occur in the same cycle, the set SHALL win.
REQ-033 SP SHALL wrap modulo 256 in both directions (0x00 push writes 0xFF; 0xFF pop yields 0x00); DEPTH SHALL never wrap.
REQ-034 SCR_WE SHALL be 0 in every state except PUSH_WR, and SCR_ADDR SHALL equal SP whenever the FSM is outside PUSH_WR and POP_RD.
REQ-035 Latency: push write occurs one cycle after transfer; POP_VALID occurs three cycles after transfer; the next command can be accepted in the cycle after the FSM returns to IDLE.

Reset
REQ-036 When RST is asserted, asynchronously: FSM=IDLE, SP=SP_RESET, DEPTH=0, POP_DATA=0, POP_VALID=0, SCR_WE=0, OVF_ERR=0 and UNF_ERR=0; SCR_ADDR SHALL follow SP.
REQ-037 Reset during PUSH_WR, POP_RD or POP_CAP SHALL abandon the operation with no SP or DEPTH update; a write in flight may be truncated by the reset.

Structure
REQ-038 A shared package SHALL hold the stack_op_t enum (LOAD/PUSH/POP/NOP), the stack_state_t enum, and the constant SP_W=8.
REQ-039 The block SHALL be a single module with no sub-modules; the scratch RAM SHALL be external.

Verification
REQ-040 Reset, then push 10'h155 -> SCR_WE=1 at address 8'hFF with data 10'h155; then SP=8'hFF and DEPTH=1.
REQ-041 Push 10'h001 then 10'h002, pop twice -> POP_DATA is 10'h002 then 10'h001, each with a one-cycle POP_VALID; afterwards SP=8'h00 and EMPTY=1.
REQ-042 Pop when EMPTY -> UNF_ERR=1, no POP_VALID pulse, SP unchanged; ERR_CLR then clears UNF_ERR.
REQ-043 Perform 256 pushes -> FULL=1; a 257th push sets OVF_ERR with no write; ERR_CLR in the same cycle as that push leaves OVF_ERR=1.
REQ-044 LOAD 8'h80 with DEPTH=3 -> SP=8'h80 and DEPTH=0 at the next edge; SP_M1=8'h7F.
REQ-045 Assert RST during POP_RD -> all outputs take their reset values (REQ-036) immediately, with no POP_VALID pulse.
